// File: rtl/mdu_pkg.sv
// ----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the M-extension divide unit: default operand width,
// the decoder's mul_con codes for the divide group, and the divider FSM
// state type.
// ----------------------------------------------------------------------------
package mdu_pkg;

    localparam int DEFAULT_XLEN = 32;

    // mul_con codes produced by the main decoder for the divide group.
    // Bit 3 marks a divide op, bit 1 selects remainder, bit 0 selects unsigned.
    localparam logic [3:0] MDU_DIV  = 4'b1000;
    localparam logic [3:0] MDU_DIVU = 4'b1001;
    localparam logic [3:0] MDU_REM  = 4'b1010;
    localparam logic [3:0] MDU_REMU = 4'b1011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// ----------------------------------------------------------------------------
// div_step
// One combinational radix-2 restoring division iteration. The partial
// remainder and quotient are shifted left together as {rem, quo}; the bit
// shifted out of quo enters rem. If the shifted remainder is at least the
// divisor it is reduced and a 1 enters the quotient LSB.
//
// Ports:
//   i_rem  in  XLEN  current partial remainder
//   i_quo  in  XLEN  current partial quotient (low bits still hold dividend)
//   i_div  in  XLEN  divisor (magnitude)
//   o_rem  out XLEN  next partial remainder
//   o_quo  out XLEN  next partial quotient
// ----------------------------------------------------------------------------
module div_step
    import mdu_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_trial;

    // The shifted remainder can exceed XLEN bits, so the trial subtraction is
    // done at XLEN+1 bits; its MSB is the borrow (trial negative).
    assign w_shift = {i_rem, i_quo[XLEN-1]};
    assign w_trial = w_shift - {1'b0, i_div};

    always_comb begin
        // NOTE: outputs get a default before any condition so no path leaves
        // them unassigned, which would otherwise infer a latch.
        o_rem = w_shift[XLEN-1:0];
        o_quo = {i_quo[XLEN-2:0], 1'b0};
        if (!w_trial[XLEN]) begin
            o_rem    = w_trial[XLEN-1:0];
            o_quo[0] = 1'b1;
        end
    end

endmodule

// File: rtl/mdu_divider.sv
// ----------------------------------------------------------------------------
// mdu_divider
// Multi-cycle DIV/DIVU/REM/REMU unit for the execute stage. Signed operands
// are converted to magnitudes on accept, XLEN restoring steps run one per
// cycle, and a FIX cycle re-applies signs and selects quotient or remainder.
// Divide-by-zero and signed overflow bypass the iteration entirely.
//
// Ports:
//   clk      in  1     rising-edge clock
//   rst      in  1     asynchronous active-high reset
//   start    in  1     alu_mul_sel qualified by a valid EX instruction
//   mul_con  in  4     op code (MDU_DIV/DIVU/REM/REMU)
//   op_a     in  XLEN  dividend (rs1)
//   op_b     in  XLEN  divisor (rs2)
//   flush    in  1     abort any in-flight op
//   stall    out 1     hold PC and IF/ID/EX registers
//   done     out 1     one-cycle pulse, result valid
//   result   out XLEN  quotient or remainder, held until the next done
// ----------------------------------------------------------------------------
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      mul_con,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int               CNT_W   = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t       r_state;
    div_state_t       w_next;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_rem;
    logic [XLEN-1:0]  r_quo;
    logic [XLEN-1:0]  r_div;
    logic [XLEN-1:0]  r_result;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_sel_rem;
    logic             r_done;

    logic             w_accept;
    logic             w_signed;
    logic             w_b_zero;
    logic             w_ovf;
    logic [XLEN-1:0]  w_abs_a;
    logic [XLEN-1:0]  w_abs_b;
    logic [XLEN-1:0]  w_special_res;
    logic [XLEN-1:0]  w_rem_nxt;
    logic [XLEN-1:0]  w_quo_nxt;
    logic [XLEN-1:0]  w_quo_fix;
    logic [XLEN-1:0]  w_rem_fix;
    logic             w_unused_ok;

    // Bit 2 of mul_con distinguishes nothing within the divide group.
    assign w_unused_ok = mul_con[2];

    // flush wins over start, so a redirected instruction is never accepted.
    assign w_accept = (r_state == S_IDLE) && start && mul_con[3] && !flush;
    assign w_signed = !mul_con[0];
    assign w_b_zero = (op_b == '0);
    assign w_ovf    = w_signed && (op_a == MIN_NEG) && (op_b == '1);

    assign w_abs_a  = (w_signed && op_a[XLEN-1]) ? -op_a : op_a;
    assign w_abs_b  = (w_signed && op_b[XLEN-1]) ? -op_b : op_b;

    // Divide-by-zero returns the raw dividend as remainder regardless of
    // signedness; overflow returns MIN_NEG / 0.
    assign w_special_res = mul_con[1] ? (w_b_zero ? op_a : '0)
                                      : (w_b_zero ? '1   : MIN_NEG);

    assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
    assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

    div_step #(.XLEN(XLEN)) u_step (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_div (r_div),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = (w_b_zero || w_ovf) ? S_DONE : S_CALC;
            S_CALC:  if (r_count == LAST) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (flush) w_next = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: every register, datapath included, is cleared on reset so the
        // outputs and any later debug read are deterministic from power-up.
        if (rst) begin
            r_state   <= S_IDLE;
            r_count   <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_div     <= '0;
            r_result  <= '0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_sel_rem <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_state <= w_next;
            r_done  <= 1'b0;
            if (flush) r_count <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_count   <= '0;
                        r_rem     <= '0;
                        r_quo     <= w_abs_a;
                        r_div     <= w_abs_b;
                        r_sel_rem <= mul_con[1];
                        r_neg_q   <= w_signed && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        r_neg_r   <= w_signed && op_a[XLEN-1];
                        if (w_b_zero || w_ovf) begin
                            r_result <= w_special_res;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        r_rem   <= w_rem_nxt;
                        r_quo   <= w_quo_nxt;
                        r_count <= r_count + CNT_W'(1);
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
                        r_done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Low in DONE so the EX instruction retires on the done cycle; forced low
    // while reset is held.
    assign stall  = !rst && (w_accept || (r_state == S_CALC) || (r_state == S_FIX));
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_mdu_divider.sv
// ----------------------------------------------------------------------------
// tb_mdu_divider
// Directed self-checking bench for mdu_divider. Cycle 0 of an op is the cycle
// start is first driven; inputs change 1 time unit after the rising edge and
// outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_mdu_divider;
    import mdu_pkg::*;

    localparam int TIMEOUT = 80;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  mul_con;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int          n_checks = 0;
    int          n_fail   = 0;

    int          got_lat;
    int          got_nstall;
    logic [31:0] got_res;
    logic        got_stall_done;

    mdu_divider #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .mul_con (mul_con),
        .op_a    (op_a),
        .op_b    (op_b),
        .flush   (flush),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    // Drives one op from the current point (just after a rising edge) and
    // waits for done. Operands are scrambled after the accept cycle.
    task automatic run_op(input logic [3:0] con, input logic [31:0] a, input logic [31:0] b);
        int c;
        bit seen;
        start = 1'b1; mul_con = con; op_a = a; op_b = b;
        c = 0; seen = 1'b0;
        got_lat = -1; got_res = '0; got_nstall = 0; got_stall_done = 1'b1;
        while (!seen && c < TIMEOUT) begin
            if (c == 1) begin
                start = 1'b0; mul_con = 4'b0000; op_a = ~a; op_b = b + 32'd1;
            end
            @(negedge clk);
            if (done) begin
                seen = 1'b1; got_lat = c; got_res = result; got_stall_done = stall;
            end else begin
                if (stall) got_nstall++;
                c++;
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
    endtask

    task automatic do_vec(input string tag, input logic [3:0] con, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        @(posedge clk); #1;
        run_op(con, a, b);
        check({tag, "_res"}, got_res, exp_res);
        check({tag, "_lat"}, got_lat, exp_lat);
    endtask

    initial begin
        int          n_done;
        int          n_stall;
        int          done_cyc[2];
        logic [31:0] done_res[2];
        logic        stall_at_34;

        rst = 1'b1; start = 1'b0; flush = 1'b0; mul_con = 4'b0000; op_a = '0; op_b = '0;
        #12;
        check("reset_stall",  stall,  0);
        check("reset_done",   done,   0);
        check("reset_result", result, 0);
        @(negedge clk); rst = 1'b0;

        // Main function and latency.
        do_vec("div_100_7", MDU_DIV, 32'd100, 32'd7, 32'd14, 34);
        check("div_100_7_nstall", got_nstall, 34);
        check("div_100_7_stall_done", got_stall_done, 0);
        do_vec("rem_100_7",   MDU_REM,  32'd100,       32'd7, 32'd2,         34);
        do_vec("div_m7_2",    MDU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
        do_vec("rem_m7_2",    MDU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
        do_vec("divu_big_2",  MDU_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 34);

        // Bypass cases: done in cycle 1.
        do_vec("divu_5_0", MDU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        check("divu_5_0_nstall", got_nstall, 1);
        check("divu_5_0_stall_done", got_stall_done, 0);
        do_vec("remu_5_0", MDU_REMU, 32'd5,         32'd0,         32'd5,         1);
        do_vec("div_ovf",  MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_vec("rem_ovf",  MDU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        do_vec("div_m7_0", MDU_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 1);
        do_vec("rem_m7_0", MDU_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1);

        // Flush in cycle 10 of DIV 100/7; result keeps 0xFFFF_FFF9.
        @(posedge clk); #1;
        start = 1'b1; mul_con = MDU_DIV; op_a = 32'd100; op_b = 32'd7;
        n_done = 0;
        for (int c = 0; c <= 10; c++) begin
            if (c == 1)  start = 1'b0;
            if (c == 10) flush = 1'b1;
            @(negedge clk);
            if (done) n_done++;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        #1;
        check("flush_stall",    stall,  0);
        check("flush_no_done",  n_done + int'(done), 0);
        check("flush_result",   result, 32'hFFFF_FFF9);
        run_op(MDU_DIVU, 32'd9, 32'd3);
        check("after_flush_res", got_res, 32'd3);
        check("after_flush_lat", got_lat, 34);

        // flush and start together: nothing is accepted.
        @(posedge clk); #1;
        start = 1'b1; flush = 1'b1; mul_con = MDU_DIVU; op_a = 32'd9; op_b = 32'd3;
        @(negedge clk);
        check("flush_start_stall", stall, 0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        n_done = 0; n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done)  n_done++;
            if (stall) n_stall++;
        end
        check("flush_start_no_done",  n_done,  0);
        check("flush_start_no_stall", n_stall, 0);

        // start held through DONE, then an immediate REMU 17/5.
        @(posedge clk); #1;
        start = 1'b1; mul_con = MDU_DIV; op_a = 32'd100; op_b = 32'd7;
        n_done = 0; stall_at_34 = 1'b1;
        done_cyc[0] = -1; done_cyc[1] = -1; done_res[0] = '0; done_res[1] = '0;
        for (int c = 0; c < 120; c++) begin
            if (c == 35) begin mul_con = MDU_REMU; op_a = 32'd17; op_b = 32'd5; end
            if (c == 36) start = 1'b0;
            @(negedge clk);
            if (c == 34) stall_at_34 = stall;
            if (done) begin
                if (n_done < 2) begin
                    done_cyc[n_done] = c;
                    done_res[n_done] = result;
                end
                n_done++;
            end
            @(posedge clk); #1;
        end
        check("held_n_done",     n_done,      2);
        check("held_cyc0",       done_cyc[0], 34);
        check("held_res0",       done_res[0], 32'd14);
        check("held_stall_done", stall_at_34, 0);
        check("held_cyc1",       done_cyc[1], 69);
        check("held_res1",       done_res[1], 32'd2);

        // Asynchronous reset in the middle of CALC.
        start = 1'b1; mul_con = MDU_DIV; op_a = 32'd100; op_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        check("pre_rst_stall", stall, 1);
        rst = 1'b1;
        #1;
        check("rst_async_stall",  stall,  0);
        check("rst_async_done",   done,   0);
        check("rst_async_result", result, 0);
        @(negedge clk); rst = 1'b0;
        n_done = 0; n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done)  n_done++;
            if (stall) n_stall++;
        end
        check("post_rst_no_done",  n_done,  0);
        check("post_rst_no_stall", n_stall, 0);
        do_vec("post_rst_remu_17_5", MDU_REMU, 32'd17, 32'd5, 32'd2, 34);

        // Non-divide op code is ignored.
        @(posedge clk); #1;
        start = 1'b1; mul_con = 4'b0000; op_a = 32'd100; op_b = 32'd7;
        n_done = 0; n_stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done)  n_done++;
            if (stall) n_stall++;
        end
        start = 1'b0;
        check("nondiv_no_stall", n_stall, 0);
        check("nondiv_no_done",  n_done,  0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
